// File: rtl/mastermind_engine.sv
// mastermind_engine
//   Parametrised Mastermind game core. It holds the secret code, takes
//   guesses over a valid/ready handshake, and scores each one sequentially:
//   one cycle for exact matches, then one cycle per colour to accumulate the
//   min-count colour matches, then one report cycle. The score is published
//   on the edge that leaves REPORT. A per-turn history buffer records every
//   scored guess, and sticky won/lost flags end the game.
//
// Optional feature (macro GUESS_CHECK_EN):
//   When defined, a guess holding any peg >= NUM_COLORS is rejected. It
//   skips the colour sweep, reports guess_err=1 with exact=partial=0, and
//   does not consume a turn. When undefined, guess_err is always 0 and
//   out-of-range pegs are scored like any other value.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   new_game, code_in     restart pulse and secret code (peg i at [i*COLOR_W +: COLOR_W])
//   guess_valid/ready     guess handshake, guess_in uses the same packing
//   result_valid          one-cycle pulse when exact/partial/guess_err update
//   exact, partial        score of the last reported guess (held)
//   guess_err             last guess rejected as out of range
//   turn                  number of guesses scored this game
//   game_won, game_lost   sticky end-of-game flags
//   hist_sel              history read index
//   hist_guess/exact/partial  combinational history read (zeros if unused slot)

module mastermind_engine #(
  parameter int PEGS       = 4,
  parameter int COLOR_W    = 3,
  parameter int NUM_COLORS = 6,
  parameter int MAX_TURNS  = 8,
  parameter int TURN_W     = 4,
  parameter int CNT_W      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_game,
  input  logic [PEGS*COLOR_W-1:0]   code_in,
  input  logic                      guess_valid,
  output logic                      guess_ready,
  input  logic [PEGS*COLOR_W-1:0]   guess_in,
  output logic                      result_valid,
  output logic [CNT_W-1:0]          exact,
  output logic [CNT_W-1:0]          partial,
  output logic                      guess_err,
  output logic [TURN_W-1:0]         turn,
  output logic                      game_won,
  output logic                      game_lost,
  input  logic [TURN_W-1:0]         hist_sel,
  output logic [PEGS*COLOR_W-1:0]   hist_guess,
  output logic [CNT_W-1:0]          hist_exact,
  output logic [CNT_W-1:0]          hist_partial
);

  localparam int CODE_W = PEGS * COLOR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_EXACT,
    S_COLORS,
    S_REPORT,
    S_DONE
  } state_t;

  // Control state (reset)
  state_t              state_q, state_d;
  logic                result_valid_q, result_valid_d;
  logic [CNT_W-1:0]    exact_q, exact_d;
  logic [CNT_W-1:0]    partial_q, partial_d;
  logic                guess_err_q, guess_err_d;
  logic                err_q, err_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                won_q, won_d;
  logic                lost_q, lost_d;
  logic [MAX_TURNS-1:0] hist_valid_q, hist_valid_d;

  // Datapath state (no reset needed, always written before use)
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   guess_q, guess_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    score_exact_q, score_exact_d;
  logic [CODE_W-1:0]   hist_guess_q   [MAX_TURNS];
  logic [CODE_W-1:0]   hist_guess_d   [MAX_TURNS];
  logic [CNT_W-1:0]    hist_exact_q   [MAX_TURNS];
  logic [CNT_W-1:0]    hist_exact_d   [MAX_TURNS];
  logic [CNT_W-1:0]    hist_partial_q [MAX_TURNS];
  logic [CNT_W-1:0]    hist_partial_d [MAX_TURNS];

  logic [CNT_W-1:0]    exact_cnt;
  logic [CNT_W-1:0]    code_cnt;
  logic [CNT_W-1:0]    guess_cnt;
  logic [CNT_W-1:0]    min_cnt;
  logic                range_err;

  // Per-slot exact matches, and occurrences of the current sweep colour in
  // code and guess; the smaller occurrence count is the colour's contribution
  // to the total match count, which makes duplicates score correctly.
  always_comb begin
    exact_cnt = '0;
    code_cnt  = '0;
    guess_cnt = '0;
    for (int i = 0; i < PEGS; i++) begin
      if (guess_q[i*COLOR_W +: COLOR_W] == code_q[i*COLOR_W +: COLOR_W])
        exact_cnt = exact_cnt + CNT_W'(1);
      if (code_q[i*COLOR_W +: COLOR_W] == color_q)
        code_cnt = code_cnt + CNT_W'(1);
      if (guess_q[i*COLOR_W +: COLOR_W] == color_q)
        guess_cnt = guess_cnt + CNT_W'(1);
    end
    min_cnt = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
  end

`ifdef GUESS_CHECK_EN
  // Any guess peg outside the legal colour range rejects the whole guess.
  always_comb begin
    range_err = 1'b0;
    for (int i = 0; i < PEGS; i++) begin
      if ({1'b0, guess_q[i*COLOR_W +: COLOR_W]} >= (COLOR_W+1)'(NUM_COLORS))
        range_err = 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

  // Next-state and datapath update. new_game is applied last so it overrides
  // whatever the current state would have done, including a pending report.
  always_comb begin
    state_d        = state_q;
    result_valid_d = 1'b0;
    exact_d        = exact_q;
    partial_d      = partial_q;
    guess_err_d    = guess_err_q;
    err_d          = err_q;
    turn_d         = turn_q;
    won_d          = won_q;
    lost_d         = lost_q;
    hist_valid_d   = hist_valid_q;
    code_d         = code_q;
    guess_d        = guess_q;
    color_d        = color_q;
    acc_d          = acc_q;
    score_exact_d  = score_exact_q;
    for (int i = 0; i < MAX_TURNS; i++) begin
      hist_guess_d[i]   = hist_guess_q[i];
      hist_exact_d[i]   = hist_exact_q[i];
      hist_partial_d[i] = hist_partial_q[i];
    end

    case (state_q)
      S_IDLE: begin
      end

      S_READY: begin
        if (guess_valid) begin
          guess_d     = guess_in;
          guess_err_d = 1'b0;
          state_d     = S_EXACT;
        end
      end

      S_EXACT: begin
        score_exact_d = exact_cnt;
        color_d       = '0;
        acc_d         = '0;
        err_d         = range_err;
        state_d       = range_err ? S_REPORT : S_COLORS;
      end

      S_COLORS: begin
        acc_d   = acc_q + min_cnt;
        color_d = color_q + COLOR_W'(1);
        if (color_q == COLOR_W'(NUM_COLORS - 1))
          state_d = S_REPORT;
      end

      S_REPORT: begin
        result_valid_d = 1'b1;
        if (err_q) begin
          exact_d     = '0;
          partial_d   = '0;
          guess_err_d = 1'b1;
          err_d       = 1'b0;
          state_d     = S_READY;
        end else begin
          exact_d     = score_exact_q;
          // Total colour matches include the exact ones; remove them.
          partial_d   = acc_q - score_exact_q;
          guess_err_d = 1'b0;
          turn_d      = turn_q + TURN_W'(1);
          for (int i = 0; i < MAX_TURNS; i++) begin
            if (turn_q == TURN_W'(i)) begin
              hist_guess_d[i]   = guess_q;
              hist_exact_d[i]   = score_exact_q;
              hist_partial_d[i] = acc_q - score_exact_q;
              hist_valid_d[i]   = 1'b1;
            end
          end
          if (score_exact_q == CNT_W'(PEGS)) begin
            won_d   = 1'b1;
            state_d = S_DONE;
          end else if (turn_q + TURN_W'(1) == TURN_W'(MAX_TURNS)) begin
            lost_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_READY;
          end
        end
      end

      S_DONE: begin
      end

      default: state_d = S_IDLE;
    endcase

    if (new_game) begin
      code_d         = code_in;
      state_d        = S_READY;
      result_valid_d = 1'b0;
      exact_d        = '0;
      partial_d      = '0;
      guess_err_d    = 1'b0;
      err_d          = 1'b0;
      turn_d         = '0;
      won_d          = 1'b0;
      lost_d         = 1'b0;
      hist_valid_d   = '0;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      result_valid_q <= 1'b0;
      exact_q        <= '0;
      partial_q      <= '0;
      guess_err_q    <= 1'b0;
      err_q          <= 1'b0;
      turn_q         <= '0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
      hist_valid_q   <= '0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= result_valid_d;
      exact_q        <= exact_d;
      partial_q      <= partial_d;
      guess_err_q    <= guess_err_d;
      err_q          <= err_d;
      turn_q         <= turn_d;
      won_q          <= won_d;
      lost_q         <= lost_d;
      hist_valid_q   <= hist_valid_d;
    end
  end

  // Datapath registers; their contents only matter once a valid bit or the
  // FSM says so, so they carry no reset.
  always_ff @(posedge clk) begin
    code_q        <= code_d;
    guess_q       <= guess_d;
    color_q       <= color_d;
    acc_q         <= acc_d;
    score_exact_q <= score_exact_d;
    for (int i = 0; i < MAX_TURNS; i++) begin
      hist_guess_q[i]   <= hist_guess_d[i];
      hist_exact_q[i]   <= hist_exact_d[i];
      hist_partial_q[i] <= hist_partial_d[i];
    end
  end

  // History read: slots not yet written this game read back as zeros.
  always_comb begin
    hist_guess   = '0;
    hist_exact   = '0;
    hist_partial = '0;
    for (int i = 0; i < MAX_TURNS; i++) begin
      if (hist_sel == TURN_W'(i) && hist_sel < turn_q && hist_valid_q[i]) begin
        hist_guess   = hist_guess_q[i];
        hist_exact   = hist_exact_q[i];
        hist_partial = hist_partial_q[i];
      end
    end
  end

  assign guess_ready  = (state_q == S_READY);
  assign result_valid = result_valid_q;
  assign exact        = exact_q;
  assign partial      = partial_q;
  assign guess_err    = guess_err_q;
  assign turn         = turn_q;
  assign game_won     = won_q;
  assign game_lost    = lost_q;

endmodule

// File: tb/tb_mastermind_engine.sv
// tb_mastermind_engine
//   Directed, table-driven bench for mastermind_engine with default
//   parameters (4 pegs, 3-bit colours, 6 colours, 8 turns). Single-guess
//   scoring cases come from a vector table; multi-cycle behaviour (history,
//   loss, abort by new_game or reset, rejected guesses) uses hand sequences.
//   Inputs change on the falling edge; outputs are read on the falling edge.

module tb_mastermind_engine;

  localparam int CW = 12;

  logic          clk;
  logic          reset;
  logic          new_game;
  logic [CW-1:0] code_in;
  logic          guess_valid;
  logic          guess_ready;
  logic [CW-1:0] guess_in;
  logic          result_valid;
  logic [2:0]    exact;
  logic [2:0]    partial;
  logic          guess_err;
  logic [3:0]    turn;
  logic          game_won;
  logic          game_lost;
  logic [3:0]    hist_sel;
  logic [CW-1:0] hist_guess;
  logic [2:0]    hist_exact;
  logic [2:0]    hist_partial;

  int checks = 0;
  int errors = 0;

  mastermind_engine dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .code_in      (code_in),
    .guess_valid  (guess_valid),
    .guess_ready  (guess_ready),
    .guess_in     (guess_in),
    .result_valid (result_valid),
    .exact        (exact),
    .partial      (partial),
    .guess_err    (guess_err),
    .turn         (turn),
    .game_won     (game_won),
    .game_lost    (game_lost),
    .hist_sel     (hist_sel),
    .hist_guess   (hist_guess),
    .hist_exact   (hist_exact),
    .hist_partial (hist_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] code;
    logic [CW-1:0] guess;
    int            exp_exact;
    int            exp_partial;
    bit            exp_won;
  } vec_t;

  typedef struct {
    logic [CW-1:0] guess;
    int            exp_exact;
    int            exp_partial;
  } turn_t;

  // Pack pegs written most-significant first: {p3, p2, p1, p0}.
  function automatic logic [CW-1:0] pk(input int p3, input int p2, input int p1, input int p0);
    logic [2:0] a, b, c, d;
    a = p3[2:0];
    b = p2[2:0];
    c = p1[2:0];
    d = p0[2:0];
    return {a, b, c, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doNewGame(input logic [CW-1:0] code);
    new_game = 1'b1;
    code_in  = code;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  // Present one guess for one edge; the engine must be ready to take it.
  task automatic applyStimulus(input string name, input logic [CW-1:0] g);
    checkOutput({name, " ready"}, guess_ready, 1);
    guess_valid = 1'b1;
    guess_in    = g;
    @(negedge clk);
    guess_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until result_valid; bounded.
  task automatic waitResult(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expectQuiet(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen++;
    end
    checkOutput(name, seen, 0);
  endtask

  task automatic scoreGuess(input string name, input logic [CW-1:0] g, input int exp_lat,
                            input int exp_e, input int exp_p);
    int lat;
    applyStimulus(name, g);
    waitResult(lat);
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " exact"}, exact, exp_e);
    checkOutput({name, " partial"}, partial, exp_p);
    checkOutput({name, " guess_err"}, guess_err, 0);
    @(negedge clk);
    checkOutput({name, " rv pulse"}, result_valid, 0);
  endtask

  vec_t  vecs [10];
  turn_t turns[8];

  initial begin
    int lat;

    reset       = 1'b1;
    new_game    = 1'b0;
    code_in     = '0;
    guess_valid = 1'b0;
    guess_in    = '0;
    hist_sel    = '0;

    vecs[0] = '{pk(4,3,2,1), pk(4,3,2,1), 4, 0, 1'b1};
    vecs[1] = '{pk(2,2,1,1), pk(1,1,2,2), 0, 4, 1'b0};
    vecs[2] = '{pk(2,2,1,1), pk(2,1,5,5), 1, 1, 1'b0};
    vecs[3] = '{pk(0,1,2,3), pk(3,2,1,0), 0, 4, 1'b0};
    vecs[4] = '{pk(5,5,5,5), pk(5,0,0,0), 1, 0, 1'b0};
    vecs[5] = '{pk(0,1,2,3), pk(4,4,4,4), 0, 0, 1'b0};
    vecs[6] = '{pk(1,2,3,4), pk(1,2,4,3), 2, 2, 1'b0};
    vecs[7] = '{pk(0,0,1,1), pk(1,0,0,0), 1, 2, 1'b0};
    vecs[8] = '{pk(3,3,3,3), pk(3,3,3,2), 3, 0, 1'b0};
    vecs[9] = '{pk(5,4,3,2), pk(2,3,4,5), 0, 4, 1'b0};

    turns[0] = '{pk(0,0,0,0), 0, 0};
    turns[1] = '{pk(1,1,1,1), 0, 0};
    turns[2] = '{pk(2,0,0,0), 0, 1};
    turns[3] = '{pk(5,0,0,0), 1, 0};
    turns[4] = '{pk(2,3,4,5), 0, 4};
    turns[5] = '{pk(5,4,3,1), 3, 0};
    turns[6] = '{pk(4,5,2,3), 0, 4};
    turns[7] = '{pk(0,4,0,0), 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset ready", guess_ready, 0);
    checkOutput("reset result_valid", result_valid, 0);
    checkOutput("reset exact", exact, 0);
    checkOutput("reset partial", partial, 0);
    checkOutput("reset turn", turn, 0);
    checkOutput("reset won", game_won, 0);
    checkOutput("reset lost", game_lost, 0);
    checkOutput("reset guess_err", guess_err, 0);
    checkOutput("reset hist_guess", hist_guess, 0);

    // Guesses are ignored in IDLE
    guess_valid = 1'b1;
    guess_in    = pk(1,2,3,4);
    expectQuiet("idle ignores guess", 12);
    guess_valid = 1'b0;
    checkOutput("idle ready", guess_ready, 0);

    // Start of game
    doNewGame(pk(4,3,2,1));
    checkOutput("newgame ready", guess_ready, 1);
    checkOutput("newgame turn", turn, 0);
    checkOutput("newgame won", game_won, 0);
    checkOutput("newgame lost", game_lost, 0);

    // Table of single-guess games
    for (int i = 0; i < 10; i++) begin
      doNewGame(vecs[i].code);
      scoreGuess($sformatf("vec%0d", i), vecs[i].guess, 8, vecs[i].exp_exact, vecs[i].exp_partial);
      checkOutput($sformatf("vec%0d turn", i), turn, 1);
      checkOutput($sformatf("vec%0d won", i), game_won, vecs[i].exp_won);
      checkOutput($sformatf("vec%0d lost", i), game_lost, 0);
      checkOutput($sformatf("vec%0d ready", i), guess_ready, vecs[i].exp_won ? 0 : 1);
      hist_sel = 4'd0;
      #1;
      checkOutput($sformatf("vec%0d hist0", i), hist_guess, vecs[i].guess);
    end

    // Two guesses in one game with history readback
    doNewGame(pk(2,2,1,1));
    scoreGuess("t3a", pk(1,1,2,2), 8, 0, 4);
    scoreGuess("t3b", pk(2,1,5,5), 8, 1, 1);
    checkOutput("t3 turn", turn, 2);
    hist_sel = 4'd0;
    #1;
    checkOutput("t3 hist0 guess", hist_guess, pk(1,1,2,2));
    checkOutput("t3 hist0 exact", hist_exact, 0);
    checkOutput("t3 hist0 partial", hist_partial, 4);
    hist_sel = 4'd1;
    #1;
    checkOutput("t3 hist1 guess", hist_guess, pk(2,1,5,5));
    checkOutput("t3 hist1 exact", hist_exact, 1);
    checkOutput("t3 hist1 partial", hist_partial, 1);
    hist_sel = 4'd2;
    #1;
    checkOutput("t3 hist2 guess", hist_guess, 0);

    // Eight misses lose the game
    doNewGame(pk(5,4,3,2));
    for (int k = 0; k < 8; k++) begin
      scoreGuess($sformatf("t4 g%0d", k), turns[k].guess, 8, turns[k].exp_exact, turns[k].exp_partial);
      checkOutput($sformatf("t4 g%0d turn", k), turn, k + 1);
    end
    checkOutput("t4 lost", game_lost, 1);
    checkOutput("t4 won", game_won, 0);
    checkOutput("t4 ready", guess_ready, 0);
    for (int k = 0; k < 9; k++) begin
      hist_sel = 4'(k);
      #1;
      checkOutput($sformatf("t4 hist%0d guess", k), hist_guess, (k < 8) ? turns[k].guess : 0);
      checkOutput($sformatf("t4 hist%0d exact", k), hist_exact, (k < 8) ? turns[k].exp_exact : 0);
      checkOutput($sformatf("t4 hist%0d partial", k), hist_partial, (k < 8) ? turns[k].exp_partial : 0);
    end
    hist_sel = 4'd15;
    #1;
    checkOutput("t4 hist15 guess", hist_guess, 0);
    guess_valid = 1'b1;
    guess_in    = pk(5,4,3,2);
    expectQuiet("t4 done ignores guess", 12);
    guess_valid = 1'b0;
    checkOutput("t4 done turn", turn, 8);
    checkOutput("t4 done won", game_won, 0);

    // new_game aborts an in-flight score
    doNewGame(pk(4,3,2,1));
    scoreGuess("t5 pre", pk(4,3,1,2), 8, 2, 2);
    checkOutput("t5 pre turn", turn, 1);
    applyStimulus("t5 abort", pk(1,2,3,4));
    @(negedge clk);
    @(negedge clk);
    doNewGame(pk(4,3,2,1));
    checkOutput("t5 ready", guess_ready, 1);
    checkOutput("t5 turn", turn, 0);
    checkOutput("t5 exact", exact, 0);
    checkOutput("t5 partial", partial, 0);
    hist_sel = 4'd0;
    #1;
    checkOutput("t5 hist0", hist_guess, 0);
    expectQuiet("t5 no result", 12);
    checkOutput("t5 turn later", turn, 0);

    // new_game wins over a simultaneous guess
    new_game    = 1'b1;
    code_in     = pk(4,3,2,1);
    guess_valid = 1'b1;
    guess_in    = pk(4,3,2,1);
    @(negedge clk);
    new_game    = 1'b0;
    guess_valid = 1'b0;
    checkOutput("t5 simul ready", guess_ready, 1);
    expectQuiet("t5 simul no result", 12);
    scoreGuess("t5 win", pk(4,3,2,1), 8, 4, 0);
    checkOutput("t5 win won", game_won, 1);
    checkOutput("t5 win turn", turn, 1);

    // Out-of-range guess peg
    doNewGame(pk(4,3,2,1));
    checkOutput("t6 won cleared", game_won, 0);
    scoreGuess("t6 first", pk(1,1,1,1), 8, 1, 0);
`ifdef GUESS_CHECK_EN
    applyStimulus("t6 bad", pk(7,0,0,0));
    waitResult(lat);
    checkOutput("t6 bad latency", lat, 2);
    checkOutput("t6 bad guess_err", guess_err, 1);
    checkOutput("t6 bad exact", exact, 0);
    checkOutput("t6 bad partial", partial, 0);
    checkOutput("t6 bad turn", turn, 1);
    @(negedge clk);
    checkOutput("t6 bad rv pulse", result_valid, 0);
    applyStimulus("t6 next", pk(4,3,2,1));
    checkOutput("t6 err cleared", guess_err, 0);
    waitResult(lat);
    checkOutput("t6 next latency", lat, 8);
    checkOutput("t6 next exact", exact, 4);
    checkOutput("t6 next turn", turn, 2);
    checkOutput("t6 next won", game_won, 1);
`else
    scoreGuess("t6 bad", pk(7,0,0,0), 8, 0, 0);
    checkOutput("t6 bad turn", turn, 2);
    hist_sel = 4'd1;
    #1;
    checkOutput("t6 hist1", hist_guess, pk(7,0,0,0));
`endif

    // Reset in the middle of scoring
    doNewGame(pk(4,3,2,1));
    applyStimulus("t7", pk(4,3,2,1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t7 ready", guess_ready, 0);
    checkOutput("t7 turn", turn, 0);
    checkOutput("t7 exact", exact, 0);
    checkOutput("t7 won", game_won, 0);
    expectQuiet("t7 no result", 12);
    checkOutput("t7 won later", game_won, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mastermind_engine.md
Name: mastermind_engine

Overview:
Parametrised Mastermind game core. It owns the secret code, accepts guesses over a valid/ready handshake, and scores each guess sequentially into exact (right colour, right slot) and partial (right colour, wrong slot) counts. It keeps a per-turn history buffer and flags win or loss. It sits between the guess entry/PRNG logic and the LED/SSD display drivers, and generalises the fixed 4-peg, 3-bit game to any peg count, colour count and turn limit.

Parameters:
PEGS, 4, number of pegs per code/guess
COLOR_W, 3, bits per peg
NUM_COLORS, 6, legal colours 0..NUM_COLORS-1 (NUM_COLORS <= 2**COLOR_W)
MAX_TURNS, 8, guesses allowed per game
TURN_W, 4, turn counter width (2**TURN_W > MAX_TURNS)
CNT_W, 3, score count width (2**CNT_W > PEGS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_game  in  1  pulse; latch code_in and restart the game
code_in  in  PEGS*COLOR_W  secret code; peg i at bits [i*COLOR_W +: COLOR_W]
guess_valid  in  1  guess_in is valid
guess_ready  out  1  engine can accept a guess
guess_in  in  PEGS*COLOR_W  guess, same packing as code_in
result_valid  out  1  one-cycle pulse; exact/partial/guess_err are valid
exact  out  CNT_W  exact-match count of the last scored guess
partial  out  CNT_W  colour-only match count of the last scored guess
guess_err  out  1  last guess rejected (see Optional Feature)
turn  out  TURN_W  number of guesses scored this game
game_won  out  1  sticky until new_game/reset
game_lost  out  1  sticky until new_game/reset
hist_sel  in  TURN_W  history read index
hist_guess  out  PEGS*COLOR_W  stored guess at hist_sel (combinational read)
hist_exact  out  CNT_W  stored exact count at hist_sel
hist_partial  out  CNT_W  stored partial count at hist_sel

Behaviour:
- Reset: FSM goes to IDLE; all outputs 0; turn=0; history valid bits cleared. The stored code is don't-care.
- FSM states: IDLE, READY, EXACT, COLORS, REPORT, DONE.
- IDLE: guess_ready=0. On new_game, latch code_in and go to READY.
- READY: guess_ready=1. The handshake completes on a clock edge with guess_valid=1, guess_ready=1 and new_game=0. On that edge, latch guess_in and go to EXACT.
- EXACT (1 cycle): exact = count of i where guess[i]==code[i]. Clear colour index c and the min-sum accumulator.
- COLORS (NUM_COLORS cycles): each cycle, accumulator += min(count of c in code, count of c in guess); then c++. Leave after c==NUM_COLORS-1.
- REPORT (1 cycle): partial = accumulator - exact. Assert result_valid; write {guess, exact, partial} to history[turn]; turn++.
  - If exact==PEGS: set game_won and go to DONE.
  - Else if the new turn==MAX_TURNS: set game_lost and go to DONE.
  - Else go to READY.
- Latency: result_valid is high exactly NUM_COLORS+2 edges after the accepting edge. With defaults this is 8.
- exact and partial hold their value until the next REPORT.
- DONE: guess_ready=0; guess_valid is ignored. Only new_game or reset leave DONE.
- new_game in any state, including mid-score:
  - Next cycle is READY with the new code; turn=0; game_won=game_lost=0; history cleared; exact=partial=0.
  - Any in-flight score is dropped and no result_valid is produced.
  - new_game beats a simultaneous guess_valid.
- Reset asserted mid-operation aborts everything, identical to the power-up reset.
- History: MAX_TURNS entries. hist_sel >= turn or hist_sel >= MAX_TURNS returns all zeros.
- Duplicate colours are handled by the min-count rule; exact+partial <= PEGS always.
- Code pegs >= NUM_COLORS are stored as-is. The caller supplies an in-range code.

Optional Feature:
Macro GUESS_CHECK_EN.
- Defined: in EXACT, if any guess peg is >= NUM_COLORS, skip COLORS and go to REPORT.
  - REPORT then pulses result_valid with guess_err=1 and exact=partial=0.
  - No history write; turn is unchanged; return to READY.
  - Error latency is 2 edges.
  - guess_err clears at the next accepted guess.
- Undefined: guess_err is tied 0. Out-of-range pegs are scored normally and can never match an in-range colour.

Test Plan:
1. Reset, then new_game with code {p3..p0}={4,3,2,1} -> guess_ready=1 on the next cycle; turn=0; all flags 0.
2. Guess {4,3,2,1} -> result_valid exactly 8 edges after acceptance; exact=4, partial=0, game_won=1, turn=1, guess_ready stays 0.
3. Code {2,2,1,1}:
   - Guess {1,1,2,2} -> exact=0, partial=4.
   - Then guess {2,1,5,5} -> exact=1, partial=1, turn=2.
   - hist_sel=0 returns {1,1,2,2}/0/4.
4. Eight non-winning guesses -> game_lost=1 after the 8th result. hist_sel 0..7 return the guesses in order; hist_sel=8 returns zeros; further guess_valid is ignored.
5. new_game pulsed 3 cycles after a guess is accepted -> no result_valid; turn=0; guess_ready=1 the next cycle. A simultaneous guess_valid+new_game is not accepted.
6. GUESS_CHECK_EN defined, guess {7,0,0,0} -> result_valid 2 edges after acceptance with guess_err=1, turn unchanged. Without the macro -> normal 8-edge score, guess_err=0.
